mem_interface_unit: RTL and testbench
=====================================

Name: mem_interface_unit

Overview:
- Sits directly downstream of the multi-cycle control FSM, between that FSM and external unified instruction/data memory.
- Converts the level-type MemRead/MemWrite/IorD/IRWrite controls into a req/ack memory transaction.
- Captures fetched data into the Instruction Register (IR) or Memory Data Register (MDR).
- Returns a one-cycle Mem_Ready strobe; the control FSM holds its current state until it sees Mem_Ready.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, memory data width.
- TIMEOUT, 255, maximum cycles waiting for mem_ack before the access is aborted.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-low reset.
- MemRead  in  1  read request from control FSM.
- MemWrite  in  1  write request from control FSM.
- IorD  in  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  in  1  read data goes to IR (MDR is also written).
- PC  in  ADDR_W  program counter.
- ALUOut  in  ADDR_W  data address.
- B  in  DATA_W  store data.
- mem_req  out  1  memory request, held until ack or abort.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  one-cycle completion from memory.
- mem_rdata  in  DATA_W  read data, valid when mem_ack = 1.
- Instr  out  DATA_W  IR contents.
- MDR  out  DATA_W  memory data register.
- Mem_Ready  out  1  one-cycle strobe: access finished; control FSM may advance.
- Mem_Err  out  1  sticky error flag.

Behaviour:
- Reset (Reset == 0 at a rising edge): state IDLE, all outputs 0, Instr = 0, MDR = 0, Mem_Err = 0, timeout count = 0. Reset mid-transaction drops mem_req at that same edge. A late mem_ack after reset is ignored.
- FSM states: IDLE, BUSY, DONE. Encoding: 2 bits, one per state.
- IDLE, no command (MemRead = MemWrite = 0): stay in IDLE, outputs quiet.
- IDLE, command present: sample the command. Address = IorD ? ALUOut : PC.
  - Error case: address bits [1:0] != 0, or MemRead and MemWrite both 1. Go to DONE with Mem_Err set. No request is issued; IR and MDR are unchanged.
  - Otherwise: register mem_addr, mem_we = MemWrite, mem_wdata = B, and a latched copy of IRWrite. Set mem_req = 1 and go to BUSY.
- BUSY: mem_req, mem_we, mem_addr and mem_wdata stay stable. The timeout counter increments each cycle.
  - mem_ack = 1, read: MDR <= mem_rdata; if latched IRWrite, also Instr <= mem_rdata. Drop mem_req and go to DONE.
  - mem_ack = 1, write: drop mem_req and go to DONE.
  - Counter reaches TIMEOUT - 1 with no ack: drop mem_req, set Mem_Err, go to DONE. IR and MDR are unchanged.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT - 1, the ack wins.
- DONE: Mem_Ready = 1 for exactly this cycle; clear the counter; go to IDLE. The control FSM advances on this edge, so IDLE samples the next state's controls. No double issue occurs.
- Latency: command seen in cycle 0 gives mem_req high from cycle 1. With ack in cycle k (k ≥ 1), Mem_Ready is high in cycle k+1. Minimum Mem_Ready is cycle 2.
- mem_ack while not in BUSY: ignored.
- Control inputs changing while in BUSY: ignored. The contract is that the control FSM holds them stable.
- Mem_Err stays at 1 until reset. Later accesses still proceed normally.
- Width rules: no arithmetic beyond the counter. The counter is ceil(log2(TIMEOUT+1)) bits wide and saturates, never wrapping.

Decomposition:
- Shared package: state encodings (IDLE/BUSY/DONE), MIPS opcode constants (LW 6'b100011, SW 6'b101011, R 6'b000000, BEQ 6'b000100, J 6'b000010), and DATA_W/ADDR_W defaults.
- No sub-module is required. The timeout counter may optionally be split out as mem_timeout_counter.

Test Plan:
- Fetch: PC=0x00000040, MemRead=1, IRWrite=1, IorD=0, memory acks 1 cycle after req with rdata=0x8C220004 -> mem_addr=0x40, mem_we=0; Instr=MDR=0x8C220004; one Mem_Ready pulse; mem_req high exactly 1 cycle.
- Load with 3 wait cycles: IorD=1, ALUOut=0x00000100, MemRead=1, IRWrite=0, rdata=0xDEADBEEF -> MDR=0xDEADBEEF; Instr unchanged; Mem_Ready in cycle 5 after command; address stable throughout.
- Store: IorD=1, ALUOut=0x00000200, B=0x12345678, MemWrite=1 -> mem_we=1, mem_wdata=0x12345678; MDR and Instr unchanged; single Mem_Ready.
- Misaligned: ALUOut=0x00000102, MemRead=1 -> no mem_req; Mem_Ready in cycle 1; Mem_Err=1 and still 1 after a following good fetch.
- Timeout with TIMEOUT=4 and no ack -> mem_req high 4 cycles then low; Mem_Err=1; Mem_Ready once; MDR unchanged.
- Reset mid-BUSY: drive Reset=0 while req is high, then a late ack -> at that edge mem_req=0, all outputs 0, state IDLE; the late ack causes no Mem_Ready and no MDR update.

Source files
------------

// File: rtl/mem_interface_unit_pkg.sv
// ----------------------------------------------------------------------------
// mem_interface_unit_pkg
// Shared definitions for the memory interface unit of the multi-cycle MIPS
// datapath:
//   - default bus widths and timeout budget
//   - state encoding of the interface FSM (IDLE / BUSY / DONE)
//   - MIPS opcode constants used by the surrounding control FSM
//   - address alignment helper
// ----------------------------------------------------------------------------
package mem_interface_unit_pkg;

   // Default widths and abort budget for the memory handshake.
   localparam int unsigned AddrWDefault   = 32;
   localparam int unsigned DataWDefault   = 32;
   localparam int unsigned TimeoutDefault = 255;

   // Interface FSM: two-bit binary code, one value per state.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StBusy = 2'b01,
      StDone = 2'b10
   } mem_state_e;

   // MIPS primary opcodes seen by the control FSM that drives this unit.
   localparam logic [5:0] OpLw  = 6'b100011;
   localparam logic [5:0] OpSw  = 6'b101011;
   localparam logic [5:0] OpR   = 6'b000000;
   localparam logic [5:0] OpBeq = 6'b000100;
   localparam logic [5:0] OpJ   = 6'b000010;

   // Memory is word addressed; any set byte-offset bit is a fault.
   function automatic logic word_aligned(input logic [1:0] byte_offset);
      return byte_offset == 2'b00;
   endfunction

endpackage

// File: rtl/mem_interface_unit_if.sv
// ----------------------------------------------------------------------------
// mem_interface_unit_if
// Request/acknowledge bus between the memory interface unit and the unified
// instruction/data memory.
//   mem_req    master -> slave  request, held until ack or abort
//   mem_we     master -> slave  1 = write
//   mem_addr   master -> slave  word-aligned address
//   mem_wdata  master -> slave  write data
//   mem_ack    slave  -> master one-cycle completion
//   mem_rdata  slave  -> master read data, valid with mem_ack
// ----------------------------------------------------------------------------
interface mem_interface_unit_if
   import mem_interface_unit_pkg::*;
#(
   parameter int unsigned ADDR_W = AddrWDefault,
   parameter int unsigned DATA_W = DataWDefault
);

   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_we,
      output mem_addr,
      output mem_wdata,
      input  mem_ack,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_we,
      input  mem_addr,
      input  mem_wdata,
      output mem_ack,
      output mem_rdata
   );

endinterface

// File: rtl/mem_interface_unit_timeout.sv
// ----------------------------------------------------------------------------
// mem_interface_unit_timeout
// Saturating wait counter for an outstanding memory request.
//   clock    in   system clock
//   Reset    in   synchronous, active-low reset
//   clear    in   return the count to zero (wins over enable)
//   enable   in   count one more waiting cycle
//   expired  out  count has reached TIMEOUT - 1
// ----------------------------------------------------------------------------
module mem_interface_unit_timeout
   import mem_interface_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic clock,
   input  logic Reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);
   localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};

   logic [CntW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != CntMax)) begin
         // Saturate rather than wrap so a stuck enable can never re-arm.
         count_d = count_q + CntW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == CntLimit);

endmodule

// File: rtl/mem_interface_unit.sv
// ----------------------------------------------------------------------------
// mem_interface_unit
// Turns the level-type MemRead/MemWrite/IorD/IRWrite controls of the
// multi-cycle control FSM into a single req/ack memory transaction, captures
// read data into IR and/or MDR, and returns a one-cycle Mem_Ready strobe.
//   clock      in   system clock
//   Reset      in   synchronous, active-low reset
//   MemRead    in   read request
//   MemWrite   in   write request
//   IorD       in   address select: 0 = PC, 1 = ALUOut
//   IRWrite    in   read data also goes to IR
//   PC         in   program counter
//   ALUOut     in   data address
//   B          in   store data
//   mem        master side of the memory req/ack bus
//   Instr      out  instruction register
//   MDR        out  memory data register
//   Mem_Ready  out  one-cycle completion strobe
//   Mem_Err    out  sticky fault flag (misalignment, conflicting command, timeout)
// ----------------------------------------------------------------------------
module mem_interface_unit
   import mem_interface_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = AddrWDefault,
   parameter int unsigned DATA_W  = DataWDefault,
   parameter int unsigned TIMEOUT = TimeoutDefault
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic              IorD,
   input  logic              IRWrite,
   input  logic [ADDR_W-1:0] PC,
   input  logic [ADDR_W-1:0] ALUOut,
   input  logic [DATA_W-1:0] B,
   mem_interface_unit_if.master mem,
   output logic [DATA_W-1:0] Instr,
   output logic [DATA_W-1:0] MDR,
   output logic              Mem_Ready,
   output logic              Mem_Err
);

   mem_state_e state_q, state_d;

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              irw_q, irw_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic              err_q, err_d;

   logic [ADDR_W-1:0] cmd_addr;
   logic              cmd_valid;
   logic              cmd_bad;
   logic              launch;
   logic              expired;

   // Command decode in IDLE.
   assign cmd_addr  = IorD ? ALUOut : PC;
   assign cmd_valid = MemRead | MemWrite;
   assign cmd_bad   = !word_aligned(cmd_addr[1:0]) || (MemRead && MemWrite);
   assign launch    = (state_q == StIdle) && cmd_valid && !cmd_bad;

   mem_interface_unit_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock   (clock),
      .Reset   (Reset),
      .clear   (launch || (state_q == StDone)),
      .enable  (state_q == StBusy),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      irw_d   = irw_q;
      instr_d = instr_q;
      mdr_d   = mdr_q;
      err_d   = err_q;

      unique case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               if (cmd_bad) begin
                  // Faulty command: report completion without touching memory.
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  addr_d  = cmd_addr;
                  wdata_d = B;
                  we_d    = MemWrite;
                  irw_d   = IRWrite;
                  state_d = StBusy;
               end
            end
         end

         StBusy: begin
            // Ack is checked first so a last-cycle ack beats the abort.
            if (mem.mem_ack) begin
               if (!we_q) begin
                  mdr_d = mem.mem_rdata;
                  if (irw_q) begin
                     instr_d = mem.mem_rdata;
                  end
               end
               state_d = StDone;
            end else if (expired) begin
               err_d   = 1'b1;
               state_d = StDone;
            end
         end

         StDone: begin
            // Control FSM advances on this edge; IDLE then sees its new controls.
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!Reset) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         irw_q   <= 1'b0;
         instr_q <= '0;
         mdr_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         irw_q   <= irw_d;
         instr_q <= instr_d;
         mdr_q   <= mdr_d;
         err_q   <= err_d;
      end
   end

   // mem_req tracks BUSY directly, so reset drops it on the same edge.
   assign mem.mem_req   = (state_q == StBusy);
   assign mem.mem_we    = (state_q == StBusy) && we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   assign Instr     = instr_q;
   assign MDR       = mdr_q;
   assign Mem_Ready = (state_q == StDone);
   assign Mem_Err   = err_q;

endmodule

// File: tb/tb_mem_interface_unit.sv
module tb_mem_interface_unit;

   localparam int unsigned T = 4;

   logic        clock = 1'b0;
   logic        Reset;
   logic        MemRead, MemWrite, IorD, IRWrite;
   logic [31:0] PC, ALUOut, B;
   logic [31:0] Instr, MDR;
   logic        Mem_Ready, Mem_Err;

   mem_interface_unit_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

   mem_interface_unit #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (T)
   ) dut (
      .clock     (clock),
      .Reset     (Reset),
      .MemRead   (MemRead),
      .MemWrite  (MemWrite),
      .IorD      (IorD),
      .IRWrite   (IRWrite),
      .PC        (PC),
      .ALUOut    (ALUOut),
      .B         (B),
      .mem       (mem_if),
      .Instr     (Instr),
      .MDR       (MDR),
      .Mem_Ready (Mem_Ready),
      .Mem_Err   (Mem_Err)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Observations recorded by the access driver.
   int          obs_ready_cyc, obs_pulses, obs_req_cycles;
   logic        obs_stable, obs_we;
   logic [31:0] obs_addr, obs_wdata;

   // Reference state.
   logic [31:0] m_instr, m_mdr;
   logic        m_err;

   // Plays the control FSM (holds command until Mem_Ready) and the memory
   // (acks in cycle 'delay' after the command; delay 0 = never).
   task automatic run_access(input logic rd, input logic wr, input logic iord,
                             input logic irw, input logic [31:0] pc,
                             input logic [31:0] alu, input logic [31:0] b,
                             input int delay, input logic [31:0] rdata);
      MemRead = rd; MemWrite = wr; IorD = iord; IRWrite = irw;
      PC = pc; ALUOut = alu; B = b;
      mem_if.mem_ack = 1'b0;
      obs_ready_cyc = -1; obs_pulses = 0; obs_req_cycles = 0; obs_stable = 1'b1;
      obs_we = 1'b0; obs_addr = '0; obs_wdata = '0;
      if (mem_if.mem_req) obs_req_cycles++;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(posedge clock); #1;
         if (mem_if.mem_req) begin
            if (obs_req_cycles == 0) begin
               obs_addr = mem_if.mem_addr; obs_we = mem_if.mem_we; obs_wdata = mem_if.mem_wdata;
            end else if (mem_if.mem_addr != obs_addr || mem_if.mem_we != obs_we ||
                         mem_if.mem_wdata != obs_wdata) begin
               obs_stable = 1'b0;
            end
            obs_req_cycles++;
         end
         if (Mem_Ready) begin
            obs_pulses++;
            if (obs_ready_cyc < 0) obs_ready_cyc = cyc;
            MemRead = 1'b0; MemWrite = 1'b0;
         end
         mem_if.mem_ack   = (cyc == delay);
         mem_if.mem_rdata = (cyc == delay) ? rdata : $urandom;
      end
      mem_if.mem_ack = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b0; MemRead = 0; MemWrite = 0; IorD = 0; IRWrite = 0;
      PC = '0; ALUOut = '0; B = '0; mem_if.mem_ack = 0; mem_if.mem_rdata = '0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", mem_if.mem_req); end
      checks++; if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} !== 65'd0) begin errors++; $display("FAIL reset_bus: we %b addr %h wdata %h want all 0", mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata); end
      checks++; if (Instr !== 32'd0 || MDR !== 32'd0) begin errors++; $display("FAIL reset_regs: Instr %h MDR %h want 0", Instr, MDR); end
      checks++; if (Mem_Ready !== 1'b0 || Mem_Err !== 1'b0) begin errors++; $display("FAIL reset_flags: ready %b err %b want 0 0", Mem_Ready, Mem_Err); end
      Reset = 1'b1;
      m_instr = '0; m_mdr = '0; m_err = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic test_fetch();
      run_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h0, 32'h0, 1, 32'h8C22_0004);
      m_instr = 32'h8C22_0004; m_mdr = 32'h8C22_0004;
      checks++; if (obs_ready_cyc !== 2) begin errors++; $display("FAIL fetch_ready_cycle: got %0d want 2", obs_ready_cyc); end
      checks++; if (obs_req_cycles !== 1) begin errors++; $display("FAIL fetch_req_cycles: got %0d want 1", obs_req_cycles); end
      checks++; if (obs_addr !== 32'h40 || obs_we !== 1'b0) begin errors++; $display("FAIL fetch_bus: addr %h we %b want 00000040 0", obs_addr, obs_we); end
      checks++; if (Instr !== m_instr || MDR !== m_mdr) begin errors++; $display("FAIL fetch_data: Instr %h MDR %h want %h", Instr, MDR, m_instr); end
      checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL fetch_pulses: got %0d want 1", obs_pulses); end
   endtask

   task automatic test_load_wait();
      run_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0100, 32'h0, 4, 32'hDEAD_BEEF);
      m_mdr = 32'hDEAD_BEEF;
      checks++; if (obs_ready_cyc !== 5) begin errors++; $display("FAIL load_ready_cycle: got %0d want 5", obs_ready_cyc); end
      checks++; if (obs_addr !== 32'h100 || obs_stable !== 1'b1 || obs_req_cycles !== 4) begin errors++; $display("FAIL load_bus: addr %h stable %b req %0d want 00000100 1 4", obs_addr, obs_stable, obs_req_cycles); end
      checks++; if (MDR !== m_mdr || Instr !== m_instr) begin errors++; $display("FAIL load_data: MDR %h Instr %h want %h %h", MDR, Instr, m_mdr, m_instr); end
      checks++; if (Mem_Err !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", Mem_Err); end
   endtask

   task automatic test_store();
      run_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0048, 32'h0000_0200, 32'h1234_5678, 2, 32'h5555_AAAA);
      checks++; if (obs_we !== 1'b1 || obs_wdata !== 32'h1234_5678 || obs_addr !== 32'h200) begin errors++; $display("FAIL store_bus: we %b wdata %h addr %h want 1 12345678 00000200", obs_we, obs_wdata, obs_addr); end
      checks++; if (MDR !== m_mdr || Instr !== m_instr) begin errors++; $display("FAIL store_regs: MDR %h Instr %h want %h %h", MDR, Instr, m_mdr, m_instr); end
      checks++; if (obs_pulses !== 1 || obs_ready_cyc !== 3) begin errors++; $display("FAIL store_ready: pulses %0d cycle %0d want 1 3", obs_pulses, obs_ready_cyc); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd;
      run_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_004C, 32'h0000_0102, 32'h0, 1, 32'h0BAD_0BAD);
      m_err = 1'b1;
      checks++; if (obs_req_cycles !== 0 || obs_ready_cyc !== 1) begin errors++; $display("FAIL misaligned_ready: req %0d cycle %0d want 0 1", obs_req_cycles, obs_ready_cyc); end
      checks++; if (Mem_Err !== 1'b1 || MDR !== m_mdr || Instr !== m_instr) begin errors++; $display("FAIL misaligned_state: err %b MDR %h Instr %h want 1 %h %h", Mem_Err, MDR, Instr, m_mdr, m_instr); end
      rd = $urandom;
      run_access(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_004C, 32'h0, 32'h0, 2, rd);
      m_instr = rd; m_mdr = rd;
      checks++; if (Mem_Err !== 1'b1 || Instr !== m_instr || obs_ready_cyc !== 3) begin errors++; $display("FAIL misaligned_sticky: err %b Instr %h cycle %0d want 1 %h 3", Mem_Err, Instr, obs_ready_cyc, m_instr); end
   endtask

   task automatic test_timeout();
      run_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'h0, 32'h0, 0, 32'h0);
      checks++; if (obs_req_cycles !== int'(T) || obs_ready_cyc !== int'(T) + 1) begin errors++; $display("FAIL timeout_req: req %0d cycle %0d want %0d %0d", obs_req_cycles, obs_ready_cyc, T, T + 1); end
      checks++; if (obs_pulses !== 1 || Mem_Err !== 1'b1 || MDR !== m_mdr) begin errors++; $display("FAIL timeout_state: pulses %0d err %b MDR %h want 1 1 %h", obs_pulses, Mem_Err, MDR, m_mdr); end
   endtask

   task automatic test_conflict();
      run_access(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0060, 32'h0, 32'hFFFF_0000, 1, 32'h7777_7777);
      checks++; if (obs_req_cycles !== 0 || obs_ready_cyc !== 1 || Instr !== m_instr || MDR !== m_mdr) begin errors++; $display("FAIL conflict: req %0d cycle %0d Instr %h MDR %h want 0 1 %h %h", obs_req_cycles, obs_ready_cyc, Instr, MDR, m_instr, m_mdr); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 24; n++) begin
         logic        rd, wr, iord, irw, bad;
         logic [31:0] pc, alu, b, rdata, addr;
         int          delay, sel, exp_ready, exp_req;
         sel   = int'($urandom_range(0, 9));
         rd    = (sel < 6) || (sel == 9);
         wr    = (sel >= 6);
         iord  = 1'($urandom_range(0, 1));
         irw   = 1'($urandom_range(0, 1));
         pc    = $urandom & 32'hFFFF_FFFC;
         alu   = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 5) == 0) begin
            if (iord) alu[1:0] = 2'($urandom_range(1, 3));
            else      pc[1:0]  = 2'($urandom_range(1, 3));
         end
         b     = $urandom;
         rdata = $urandom;
         delay = int'($urandom_range(1, 6));
         addr  = iord ? alu : pc;
         bad   = (addr[1:0] != 2'b00) || (rd && wr);
         run_access(rd, wr, iord, irw, pc, alu, b, delay, rdata);
         if (bad) begin
            exp_ready = 1; exp_req = 0; m_err = 1'b1;
         end else if (delay <= int'(T)) begin
            exp_ready = delay + 1; exp_req = delay;
            if (rd) begin
               m_mdr = rdata;
               if (irw) m_instr = rdata;
            end
         end else begin
            exp_ready = int'(T) + 1; exp_req = int'(T); m_err = 1'b1;
         end
         checks++; if (obs_ready_cyc !== exp_ready || obs_pulses !== 1) begin errors++; $display("FAIL rand%0d_ready: cycle %0d pulses %0d want %0d 1", n, obs_ready_cyc, obs_pulses, exp_ready); end
         checks++; if (obs_req_cycles !== exp_req || obs_stable !== 1'b1) begin errors++; $display("FAIL rand%0d_req: cycles %0d stable %b want %0d 1", n, obs_req_cycles, obs_stable, exp_req); end
         if (exp_req > 0) begin
            checks++; if (obs_addr !== addr || obs_we !== wr || (wr && obs_wdata !== b)) begin errors++; $display("FAIL rand%0d_bus: addr %h we %b wdata %h want %h %b %h", n, obs_addr, obs_we, obs_wdata, addr, wr, b); end
         end
         checks++; if (MDR !== m_mdr || Instr !== m_instr || Mem_Err !== m_err) begin errors++; $display("FAIL rand%0d_state: MDR %h Instr %h err %b want %h %h %b", n, MDR, Instr, Mem_Err, m_mdr, m_instr, m_err); end
      end
   endtask

   task automatic test_reset_mid_busy();
      int pulses;
      MemRead = 1'b1; MemWrite = 1'b0; IorD = 1'b0; IRWrite = 1'b1; PC = 32'h0000_0080;
      mem_if.mem_ack = 1'b0;
      @(posedge clock); #1;
      checks++; if (mem_if.mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy_req: got %b want 1", mem_if.mem_req); end
      Reset = 1'b0;
      @(posedge clock); #1;
      Reset = 1'b1; MemRead = 1'b0;
      m_instr = '0; m_mdr = '0; m_err = 1'b0;
      checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 32'd0 || Mem_Ready !== 1'b0) begin errors++; $display("FAIL rst_busy_bus: req %b addr %h ready %b want 0 0 0", mem_if.mem_req, mem_if.mem_addr, Mem_Ready); end
      checks++; if (Instr !== 32'd0 || MDR !== 32'd0 || Mem_Err !== 1'b0) begin errors++; $display("FAIL rst_busy_regs: Instr %h MDR %h err %b want 0 0 0", Instr, MDR, Mem_Err); end
      mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock); #1;
         mem_if.mem_ack = 1'b0;
         if (Mem_Ready) pulses++;
      end
      checks++; if (pulses !== 0 || MDR !== m_mdr || mem_if.mem_req !== 1'b0) begin errors++; $display("FAIL rst_late_ack: pulses %0d MDR %h req %b want 0 %h 0", pulses, MDR, mem_if.mem_req, m_mdr); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_load_wait();
      test_store();
      test_misaligned();
      test_timeout();
      test_conflict();
      test_random();
      test_reset_mid_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
